// File: rtl/sync_packet_fifo.sv
// Packet FIFO: words are staged behind a commit pointer and become readable
// only as whole packets; the reader addresses words randomly within the head packet.
module sync_packet_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int MAX_PACKETS = 64,
  parameter int ADDR_BITS   = $clog2(DEPTH),
  parameter int DROP_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_commit,
  input  logic                 wr_rollback,
  output logic [ADDR_BITS:0]   wr_size,
  output logic [DROP_BITS-1:0] wr_drop_count,
  output logic                 rd_packet_valid,
  output logic [ADDR_BITS:0]   rd_packet_len,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_offset,
  output logic [WIDTH-1:0]     rd_data,
  input  logic                 rd_pop_packet,
  output logic [ADDR_BITS:0]   rd_size
);
  localparam int PW = ADDR_BITS + 1;
  localparam int MB = $clog2(MAX_PACKETS);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [PW-1:0]    len_mem [MAX_PACKETS];
  logic [PW-1:0]    wptr, cptr, rptr;
  logic [MB:0]      lw, lr;
  logic             ovf;

  logic             wr_ok, ovf_now, meta_full, commit_ok, commit_drop, pop_ok;
  logic [PW-1:0]    wptr_inc, len;
  logic [ADDR_BITS-1:0] rd_addr;

  assign wr_size         = PW'(DEPTH) - (wptr - rptr);
  assign rd_size         = cptr - rptr;
  assign rd_packet_valid = (lw != lr);
  assign rd_packet_len   = rd_packet_valid ? len_mem[lr[MB-1:0]] : '0;
  assign meta_full       = ((lw - lr) == (MB+1)'(MAX_PACKETS));

  // Overflow seen this cycle must already poison a same-cycle commit.
  assign wr_ok       = wr_en && (wr_size != '0) && !ovf && !wr_rollback;
  assign ovf_now     = ovf || (wr_en && (wr_size == '0));
  assign wptr_inc    = wptr + PW'(wr_ok);
  assign len         = wptr_inc - cptr;
  assign commit_ok   = wr_commit && !wr_rollback && !ovf_now && (len != '0) && !meta_full;
  assign commit_drop = wr_commit && !wr_rollback && (ovf_now || ((len != '0) && meta_full));
  assign pop_ok      = rd_pop_packet && rd_packet_valid;
  assign rd_addr     = rptr[ADDR_BITS-1:0] + rd_offset;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_BITS-1:0]] <= wr_data;
    if (commit_ok) len_mem[lw[MB-1:0]] <= len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr          <= '0;
      cptr          <= '0;
      lw            <= '0;
      ovf           <= 1'b0;
      wr_drop_count <= '0;
    end else if (wr_rollback) begin
      wptr <= cptr;
      ovf  <= 1'b0;
    end else if (wr_commit) begin
      ovf <= 1'b0;
      if (commit_ok) begin
        wptr <= wptr_inc;
        cptr <= wptr_inc;
        lw   <= lw + (MB+1)'(1);
      end else if (commit_drop) begin
        wptr <= cptr;
        if (~&wr_drop_count) wr_drop_count <= wr_drop_count + DROP_BITS'(1);
      end else begin
        wptr <= wptr_inc;
      end
    end else begin
      wptr <= wptr_inc;
      ovf  <= ovf_now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr    <= '0;
      lr      <= '0;
      rd_data <= '0;
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (pop_ok) begin
        rptr <= rptr + rd_packet_len;
        lr   <= lr + (MB+1)'(1);
      end
    end
  end
endmodule

// File: doc/sync_packet_fifo.md
SYNC_PACKET_FIFO -- requirements
Module: sync_packet_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, data words stored; power of two.
REQ-003 SHALL have parameter MAX_PACKETS, default 64, committed packet lengths stored; power of two.
REQ-004 SHALL have parameter ADDR_BITS, default $clog2(DEPTH), data pointer width.
REQ-005 SHALL have parameter DROP_BITS, default 16, drop counter width.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have ports wr_en (input, 1, push word) and wr_data (input, WIDTH, write data).
REQ-009 SHALL have ports wr_commit (input, 1, end packet) and wr_rollback (input, 1, discard uncommitted words).
REQ-010 SHALL have port wr_size, output, ADDR_BITS+1, free words.
REQ-011 SHALL have port wr_drop_count, output, DROP_BITS, packets dropped.
REQ-012 SHALL have ports rd_packet_valid (output, 1, packet available) and rd_packet_len (output, ADDR_BITS+1, head packet length).
REQ-013 SHALL have ports rd_en (input, 1), rd_offset (input, ADDR_BITS, word offset from head packet start) and rd_data (output, WIDTH).
REQ-014 SHALL have ports rd_pop_packet (input, 1, discard head packet) and rd_size (output, ADDR_BITS+1, committed words held).

Function
REQ-015 SHALL keep pointers wptr, cptr (committed), rptr, each ADDR_BITS+1 bits, modulo 2^(ADDR_BITS+1); memory address = low ADDR_BITS bits.
REQ-016 SHALL drive wr_size = DEPTH - (wptr - rptr) and rd_size = cptr - rptr combinationally from registered pointers.
REQ-017 SHALL accept a write (store word at wptr, wptr+1) only when wr_en, wr_size != 0, overflow flag clear, and wr_rollback low.
REQ-018 SHALL set a sticky overflow flag on wr_en with wr_size == 0; flag clears on the next commit or rollback.
REQ-019 SHALL on wr_commit compute len = wptr (including a write accepted that cycle) - cptr; commit with final write same cycle is legal.
REQ-020 SHALL, on commit with len > 0, overflow clear (including this cycle) and metadata not full, push len into length FIFO and set cptr = new wptr.
REQ-021 SHALL, on commit with overflow set or metadata full, restore wptr = cptr and increment wr_drop_count, saturating at all-ones.
REQ-022 SHALL treat commit with len == 0 and overflow clear as a no-op.
REQ-023 SHALL on wr_rollback set wptr = cptr, discard any same-cycle write, clear overflow; rollback takes precedence over simultaneous commit.
REQ-024 SHALL drive rd_packet_valid = length FIFO non-empty and rd_packet_len = head entry (0 when empty).
REQ-025 SHALL on rd_en read mem[rptr + rd_offset], low ADDR_BITS wrapping, presenting rd_data exactly one cycle later; rd_data holds when rd_en low.
REQ-026 SHALL on rd_pop_packet with rd_packet_valid set rptr += rd_packet_len and pop length FIFO; ignore pop when invalid.
REQ-027 SHALL make freed space visible on wr_size, and commits on rd_packet_valid/rd_size, the cycle after the causing edge.
REQ-028 SHALL support simultaneous commit and pop: both take effect, metadata count unchanged when both succeed.
REQ-029 SHALL return undefined rd_data for reads beyond rd_packet_len; no error signalled.

Reset
REQ-030 SHALL on rst_n low immediately clear wptr, cptr, rptr, overflow flag, length FIFO, wr_drop_count and rd_data to 0.
REQ-031 SHALL during reset output wr_size = DEPTH, rd_size = 0, rd_packet_valid = 0, rd_packet_len = 0; memory contents need not clear.
REQ-032 SHALL ignore all inputs while rst_n low; reset removal synchronous to clk is guaranteed by the system.

Verification (WIDTH=32, DEPTH=16, MAX_PACKETS=4)
REQ-033 SHALL test: write 5 words 0xA0..0xA4, commit with last write -> next cycle rd_packet_valid=1, rd_packet_len=5, rd_size=5, wr_size=11.
REQ-034 SHALL test: rd_en rd_offset=3 -> rd_data=0xA3 one cycle later; pop -> next cycle rd_packet_valid=0, wr_size=16.
REQ-035 SHALL test: write 17 words then commit -> nothing committed, wr_drop_count=1, wr_size=16, overflow cleared.
REQ-036 SHALL test: commit 4 one-word packets, then fifth 1-word commit -> dropped, wr_drop_count increments, rd_size=4.
REQ-037 SHALL test: 3 words, commit and rollback same cycle -> rollback wins, wr_size=16; wrap test: 3 packets of 7 with pops, data intact across address 15->0.
REQ-038 SHALL test: assert rst_n low mid-packet with committed data -> all outputs at reset values immediately, before next clk edge.
